// File: rtl/ones_count_pkg.sv
// Shared definitions for the sliced population counter: FSM encoding and
// slice / per-slice count widths.
package ones_count_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int SLICE_W = 15;
  localparam int OC_W    = 4;

endpackage

// File: rtl/oc15to4input.sv
// Combinational 15-input ones counter; result on w3..w0 (MSB first).
module oc15to4input (
  input  logic aa,
  input  logic bb,
  input  logic cc,
  input  logic dd,
  input  logic ee,
  input  logic ff,
  input  logic gg,
  input  logic hh,
  input  logic ii,
  input  logic jj,
  input  logic kk,
  input  logic ll,
  input  logic mm,
  input  logic nn,
  input  logic oo,
  output logic w3,
  output logic w2,
  output logic w1,
  output logic w0
);

  logic [14:0] w_bits;
  logic [3:0]  w_sum;

  assign w_bits = {oo, nn, mm, ll, kk, jj, ii, hh, gg, ff, ee, dd, cc, bb, aa};

  always_comb begin
    w_sum = 4'd0;
    for (int i = 0; i < 15; i++) begin
      w_sum = w_sum + {3'd0, w_bits[i]};
    end
  end

  assign {w3, w2, w1, w0} = w_sum;

endmodule

// File: rtl/ones_count_sequencer.sv
// Multi-cycle population counter: one shared 15-input ones counter walks the
// captured word LSB slice first and accumulates the per-slice counts.
module ones_count_sequencer
  import ones_count_pkg::*;
#(
  parameter int NSLICE = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [15*NSLICE-1:0]             data_in,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(15*NSLICE+1)-1:0]   count
);

  localparam int W  = SLICE_W * NSLICE;
  localparam int CW = $clog2(15*NSLICE+1);
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_shift;
  logic [CW-1:0]   r_acc;
  logic [CW-1:0]   r_count;
  logic [IW-1:0]   r_idx;
  logic [OC_W-1:0] w_slice_cnt;
  logic [CW-1:0]   w_sum;
  logic            w_accept;
  logic            w_last;

  oc15to4input u_oc (
    .aa (r_shift[0]),
    .bb (r_shift[1]),
    .cc (r_shift[2]),
    .dd (r_shift[3]),
    .ee (r_shift[4]),
    .ff (r_shift[5]),
    .gg (r_shift[6]),
    .hh (r_shift[7]),
    .ii (r_shift[8]),
    .jj (r_shift[9]),
    .kk (r_shift[10]),
    .ll (r_shift[11]),
    .mm (r_shift[12]),
    .nn (r_shift[13]),
    .oo (r_shift[14]),
    .w3 (w_slice_cnt[3]),
    .w2 (w_slice_cnt[2]),
    .w1 (w_slice_cnt[1]),
    .w0 (w_slice_cnt[0])
  );

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_idx == IW'(NSLICE - 1));
  assign w_sum    = r_acc + CW'(w_slice_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = start ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_LOAD) || (r_state == S_RUN);
    done = (r_state == S_DONE);
  end

  // The final sum is loaded into count on the RUN->DONE edge so it is valid
  // in the same cycle that done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_shift <= data_in;
      r_acc   <= '0;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_shift <= r_shift >> SLICE_W;
      r_acc   <= w_sum;
      r_idx   <= r_idx + IW'(1);
      if (w_last) begin
        r_count <= w_sum;
      end
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_ones_count_sequencer.sv
// Directed bench for ones_count_sequencer (NSLICE=4): latency, results,
// back-to-back, ignored mid-run start and asynchronous reset.
module tb_ones_count_sequencer;

  localparam int NSLICE = 4;
  localparam int W      = 60;
  localparam int CW     = 6;
  localparam int LAT    = NSLICE + 1;  // negedges from accept edge to done

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  data_in;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  int checks;
  int errors;
  logic [CW-1:0] held_count;

  ones_count_sequencer #(.NSLICE(NSLICE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered on the negedge right after the accept edge (state LOAD).
  task automatic wait_done(input logic [CW-1:0] exp, input string name,
                           input int poke_at, input logic [W-1:0] poke_d);
    int cycles;
    int busy_cycles;
    int hold_bad;
    cycles = 0;
    busy_cycles = 0;
    hold_bad = 0;
    while (done !== 1'b1 && cycles < 20) begin
      if (busy === 1'b1) busy_cycles++;
      if (count !== held_count) hold_bad++;
      if (cycles == poke_at) begin
        start = 1'b1;
        data_in = poke_d;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    checks++;
    if (cycles != LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d negedges, expected %0d", name, cycles, LAT);
    end
    checks++;
    if (busy_cycles != LAT) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cycles, LAT);
    end
    checks++;
    if (hold_bad != 0) begin
      errors++;
      $display("FAIL %s count_hold: count changed %0d times while running, expected held at %0d",
               name, hold_bad, held_count);
    end
    checks++;
    if (count !== exp || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s result: count=%0d busy=%b, expected count=%0d busy=0",
               name, count, busy, exp);
    end
    held_count = exp;
    $display("txn %-12s count=%0d expected=%0d latency=%0d", name, count, exp, cycles);
  endtask

  task automatic do_job(input logic [W-1:0] d, input logic [CW-1:0] exp, input string name);
    @(negedge clk);
    start = 1'b1;
    data_in = d;
    @(negedge clk);
    start = 1'b0;
    data_in = ~d;
    wait_done(exp, name, -1, '0);
  endtask

  task automatic check_pulse_end(input string name);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_width: done=%b one cycle after pulse, expected 0", name, done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    data_in = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b count=%0d, expected 0 0 0", busy, done, count);
    end
    $display("txn reset        busy=%b done=%b count=%0d", busy, done, count);
    held_count = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero;
    do_job(60'h0, 6'd0, "zero");
    check_pulse_end("zero");
  endtask

  task automatic test_back_to_back;
    do_job(60'hFFF_FFFF_FFFF_FFFF, 6'd60, "all_ones");
    start = 1'b1;
    data_in = 60'h0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: done=%b busy=%b, expected done=0 busy=1", done, busy);
    end
    wait_done(6'd0, "b2b_zero", -1, '0);
    check_pulse_end("b2b_zero");
  endtask

  task automatic test_patterns;
    do_job(60'hAAA_AAAA_AAAA_AAAA, 6'd30, "alt_a");
    do_job(60'h800_0000_0000_0001, 6'd2, "end_bits");
    do_job(60'h000_0000_0000_4000, 6'd1, "bit14");
    do_job(60'h000_0000_0000_8000, 6'd1, "bit15");
    do_job(60'h000_0000_0000_7FFF, 6'd15, "slice0_full");
    do_job(60'h123_4567_89AB_CDEF, 6'd32, "mixed");
  endtask

  task automatic test_start_while_busy;
    int extra_done;
    @(negedge clk);
    start = 1'b1;
    data_in = 60'hAAA_AAAA_AAAA_AAAA;
    @(negedge clk);
    start = 1'b0;
    wait_done(6'd30, "ignore_start", 2, 60'hFFF_FFFF_FFFF_FFFF);
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin
      errors++;
      $display("FAIL ignore_start_extra: %0d cycles busy/done after job, expected 0", extra_done);
    end
  endtask

  task automatic test_reset_mid_run;
    int stray;
    @(negedge clk);
    start = 1'b1;
    data_in = 60'hFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b count=%0d, expected 0 0 0", busy, done, count);
    end
    $display("txn mid_reset    busy=%b done=%b count=%0d", busy, done, count);
    held_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_release: %0d cycles busy/done after release, expected 0", stray);
    end
    do_job(60'h800_0000_0000_0001, 6'd2, "after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero();
    test_back_to_back();
    test_patterns();
    test_start_while_busy();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
